// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu operand stack: operation encodings and FSM states.
package dcpu_pkg;

    typedef enum logic [2:0] {
        OpNop     = 3'd0,
        OpPush    = 3'd1,
        OpPop     = 3'd2,
        OpReplace = 3'd3,
        OpDup     = 3'd4,
        OpSwap    = 3'd5,
        OpOver    = 3'd6
    } op_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StRefill = 1'b1
    } state_e;

endpackage

// File: rtl/dcpu_stack_ram.sv
// Single-port backing store for the deeper stack entries; synchronous read, no reset.
module dcpu_stack_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/dcpu_stack.sv
// Hardware operand stack: T and N in registers, deeper entries in a synchronous RAM.
// Optional sticky overflow/underflow flags are enabled by defining DCPU_STACK_GUARD_EN.
module dcpu_stack
    import dcpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CAP   = DEPTH + 2,
    localparam int unsigned CNT_W = $clog2(CAP + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_t,
    output logic [WIDTH-1:0] o_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf,
    output logic             o_unf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CntCap = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] Cnt1   = CNT_W'(1);
    localparam logic [CNT_W-1:0] Cnt2   = CNT_W'(2);
    localparam logic [CNT_W-1:0] Cnt3   = CNT_W'(3);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    logic             do_push;
    logic [WIDTH-1:0] push_val;
    logic             ovf_set, unf_set;

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        ram_we   = 1'b0;
        ram_addr = '0;
        do_push  = 1'b0;
        push_val = i_dat;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    case (i_op)
                        OpPush: begin
                            if (cnt_q == CntCap) ovf_set = 1'b1;
                            else                 do_push = 1'b1;
                        end
                        OpDup: begin
                            push_val = t_q;
                            if (cnt_q < Cnt1)         unf_set = 1'b1;
                            else if (cnt_q == CntCap) ovf_set = 1'b1;
                            else                      do_push = 1'b1;
                        end
                        OpOver: begin
                            push_val = n_q;
                            if (cnt_q < Cnt2)         unf_set = 1'b1;
                            else if (cnt_q == CntCap) ovf_set = 1'b1;
                            else                      do_push = 1'b1;
                        end
                        OpSwap: begin
                            if (cnt_q < Cnt2) begin
                                unf_set = 1'b1;
                            end else begin
                                t_d = n_q;
                                n_d = t_q;
                            end
                        end
                        OpReplace: begin
                            if (cnt_q < Cnt1) unf_set = 1'b1;
                            else              t_d = i_dat;
                        end
                        OpPop: begin
                            if (cnt_q < Cnt1) begin
                                unf_set = 1'b1;
                            end else begin
                                t_d   = n_q;
                                cnt_d = cnt_q - Cnt1;
                                if (cnt_q >= Cnt3) begin
                                    // N is restored from RAM on the following cycle
                                    ram_addr = AW'(cnt_q - Cnt3);
                                    state_d  = StRefill;
                                end else begin
                                    n_d = '0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end

                if (do_push) begin
                    if (cnt_q >= Cnt2) begin
                        ram_we   = 1'b1;
                        ram_addr = AW'(cnt_q - Cnt2);
                    end
                    n_d   = t_q;
                    t_d   = push_val;
                    cnt_d = cnt_q + Cnt1;
                end
            end
            StRefill: begin
                n_d     = ram_rdata;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            t_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    dcpu_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (n_q),
        .rdata_o (ram_rdata)
    );

`ifdef DCPU_STACK_GUARD_EN
    logic ovf_q, unf_q;

    // A violation in the same cycle as a clear leaves the flag set
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~i_clr) | ovf_set;
            unf_q <= (unf_q & ~i_clr) | unf_set;
        end
    end

    assign o_ovf = ovf_q;
    assign o_unf = unf_q;
`else
    logic unused_guard;
    assign unused_guard = ^{i_clr, ovf_set, unf_set};
    assign o_ovf = 1'b0;
    assign o_unf = 1'b0;
`endif

    assign o_ready = (state_q == StIdle);
    assign o_t     = t_q;
    assign o_n     = n_q;
    assign o_cnt   = cnt_q;
    assign o_full  = (cnt_q == CntCap);
    assign o_empty = (cnt_q == '0);

endmodule
